trim_rx: RTL and testbench
==========================

Name: trim_rx

Overview:
- Receiving end of the serial trim link: takes the ENCLK/DOUT pair driven by the trim generator and rebuilds the 12-bit trim code in the CLK50 domain.
- Synchronises ENCLK and data, detects ENCLK rising edges, and shifts data MSB-first.
- Publishes a complete word with a one-cycle VALID strobe.
- An inactivity timeout aborts partial frames and resynchronises the receiver.

Parameters:
WIDTH, 12, trim word length in bits (WIDTH >= 2)
TIMEOUT, 75000000, CLK50 cycles without an ENCLK rising edge before a partial frame is aborted (1.5 bit periods of the 1 Hz link clock)
TCNT_W, 27, width of timeout counter (2^TCNT_W > TIMEOUT)

Ports:
CLK50  input  1  system clock, 50 MHz
RST  input  1  asynchronous active-high reset
ENCLK  input  1  serial link clock from generator, asynchronous to CLK50
DIN  input  1  serial data (generator DOUT), MSB first, asynchronous
TRIMCODE  output  WIDTH  last completely received word
VALID  output  1  one-cycle pulse: TRIMCODE updated this cycle
BUSY  output  1  high while a frame is partially received
FRAME_ERR  output  1  one-cycle pulse: partial frame aborted by timeout

Behaviour:
- Reset (async, RST=1):
  - TRIMCODE=0, VALID=0, BUSY=0, FRAME_ERR=0.
  - Shift register=0, bit counter=0, timeout counter=0, state=IDLE.
  - ENCLK sync/history flops reset to 1, DIN sync flops reset to 0.
- Synchronisation:
  - Two-flop synchronisers on ENCLK and DIN.
  - Third flop holds previous synced ENCLK.
  - rise = synced ENCLK & ~previous; asserted 2-3 CLK50 cycles after the pin edge.
  - Bit sampled = synced DIN in the rise cycle, so DIN must be stable >= 4 CLK50 cycles either side of the ENCLK rising edge.
  - ENCLK held high across reset release produces no edge because the history flops reset to 1.
- State IDLE:
  - BUSY=0, timeout counter held at 0.
  - On rise: shift in bit, bit counter=1, go to SHIFT. BUSY=1 from the next cycle.
- State SHIFT:
  - On rise: shift_reg <= {shift_reg[WIDTH-2:0], bit}, bit counter +1, timeout counter cleared.
  - On rise with bit counter == WIDTH-1 (last bit):
    - next cycle TRIMCODE = completed word, VALID=1 for exactly one cycle;
    - bit counter=0, state=IDLE, BUSY=0.
  - No rise: timeout counter +1. When it reaches TIMEOUT-1 without a rise:
    - FRAME_ERR=1 for one cycle, state=IDLE, bit counter=0, BUSY=0;
    - TRIMCODE and VALID unchanged; partial bits discarded.
- Simultaneous events:
  - A rise in the cycle the timeout would fire wins: the bit is counted, the counter clears, no FRAME_ERR.
- Latency: VALID asserts 1 CLK50 cycle after the rise cycle of bit WIDTH-1, i.e. about 3-4 cycles after the final ENCLK pin edge.
- Back-to-back frames need no gap. A rise in the cycle after completion starts a new frame from IDLE.
- TRIMCODE holds its value between frames. It changes only together with VALID.
- Reset mid-frame discards all progress. There is no VALID or FRAME_ERR caused by reset.
- VALID and FRAME_ERR are never high in the same cycle.

Test Plan:
(all use TIMEOUT=64 for simulation; ENCLK period 40 CLK50 cycles, DIN changes on ENCLK falling edge)
1. Reset, send 0xA5C MSB first -> one VALID pulse, TRIMCODE=0xA5C, BUSY high from first bit until VALID cycle, FRAME_ERR never asserts.
2. Back-to-back 0xFFF then 0x001 with no idle gap -> two VALID pulses exactly 12 ENCLK periods apart, TRIMCODE 0xFFF then 0x001.
3. After 0x3C3 received, send 5 bits then stop ENCLK -> FRAME_ERR pulse 64 cycles after last rise, BUSY drops, TRIMCODE stays 0x3C3. A following full frame of 0x123 is received correctly.
4. Assert RST after 7 bits of 0xABC -> all outputs 0 immediately. After release, full frame 0x456 gives TRIMCODE=0x456 with exactly one VALID.
5. Hold ENCLK=1 through reset deassertion, keep it high for 100 cycles -> no bit captured, BUSY=0. The next genuine rising edge starts a frame.
6. Mid-frame, place an ENCLK rise so it is detected exactly in the cycle the timeout counter reaches 63 -> no FRAME_ERR. The bit is counted and the frame completes with the correct word.

Source files
------------

// File: rtl/trim_rx.sv
// Receiver for the serial trim link: synchronises ENCLK/DIN into CLK50 and rebuilds
// MSB-first trim words, with an inactivity timeout that aborts partial frames.
module trim_rx #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned TIMEOUT = 75000000,
  parameter int unsigned TCNT_W  = 27
) (
  input  logic             CLK50,
  input  logic             RST,
  input  logic             ENCLK,
  input  logic             DIN,
  output logic [WIDTH-1:0] TRIMCODE,
  output logic             VALID,
  output logic             BUSY,
  output logic             FRAME_ERR
);

  localparam int unsigned BCNT_W = $clog2(WIDTH);

  typedef enum logic {StIdle, StShift} state_t;

  state_t              r_state;
  logic                r_enclk_s1, r_enclk_s2, r_enclk_prev;
  logic                r_din_s1, r_din_s2;
  logic [WIDTH-1:0]    r_shift;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                w_rise;
  logic                w_bit;
  logic [WIDTH-1:0]    w_shift_next;

  // ENCLK history resets high so a clock already high at reset release is not an edge.
  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      r_enclk_s1   <= 1'b1;
      r_enclk_s2   <= 1'b1;
      r_enclk_prev <= 1'b1;
      r_din_s1     <= 1'b0;
      r_din_s2     <= 1'b0;
    end else begin
      r_enclk_s1   <= ENCLK;
      r_enclk_s2   <= r_enclk_s1;
      r_enclk_prev <= r_enclk_s2;
      r_din_s1     <= DIN;
      r_din_s2     <= r_din_s1;
    end
  end

  assign w_rise       = r_enclk_s2 & ~r_enclk_prev;
  assign w_bit        = r_din_s2;
  assign w_shift_next = {r_shift[WIDTH-2:0], w_bit};

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_bcnt    <= '0;
      r_tcnt    <= '0;
      TRIMCODE  <= '0;
      VALID     <= 1'b0;
      BUSY      <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (r_state)
        StIdle: begin
          r_tcnt <= '0;
          if (w_rise) begin
            r_shift <= w_shift_next;
            r_bcnt  <= BCNT_W'(1);
            r_state <= StShift;
            BUSY    <= 1'b1;
          end
        end
        StShift: begin
          // A rise in the timeout cycle takes priority over the abort.
          if (w_rise) begin
            r_shift <= w_shift_next;
            r_tcnt  <= '0;
            if (r_bcnt == BCNT_W'(WIDTH - 1)) begin
              TRIMCODE <= w_shift_next;
              VALID    <= 1'b1;
              r_bcnt   <= '0;
              r_state  <= StIdle;
              BUSY     <= 1'b0;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
            FRAME_ERR <= 1'b1;
            r_tcnt    <= '0;
            r_bcnt    <= '0;
            r_state   <= StIdle;
            BUSY      <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trim_rx.sv
// Bench for trim_rx: directed link scenarios plus randomized frames, every cycle compared
// against a queue-based reference model of the receiver.
module tb_trim_rx;

  localparam int unsigned W  = 12;
  localparam int unsigned TO = 64;
  localparam int unsigned TW = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         enclk;
  logic         din;
  logic [W-1:0] trimcode;
  logic         valid, busy, ferr;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [2:0]   eh, dh;
  bit           m_busy, m_valid, m_ferr;
  logic [W-1:0] m_trim;
  bit           q[$];
  int           since;

  always #5 clk = ~clk;

  trim_rx #(.WIDTH(W), .TIMEOUT(TO), .TCNT_W(TW)) dut (
    .CLK50    (clk),
    .RST      (rst),
    .ENCLK    (enclk),
    .DIN      (din),
    .TRIMCODE (trimcode),
    .VALID    (valid),
    .BUSY     (busy),
    .FRAME_ERR(ferr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    eh      = 3'b111;
    dh      = 3'b000;
    m_busy  = 0;
    m_valid = 0;
    m_ferr  = 0;
    m_trim  = '0;
    since   = 0;
    q.delete();
  endtask

  // Pin edges become visible to the receiver two samples late.
  task automatic model_edge();
    bit rise, b;
    rise    = eh[1] & ~eh[2];
    b       = dh[1];
    m_valid = 0;
    m_ferr  = 0;
    if (rise) begin
      q.push_back(b);
      since  = 0;
      m_busy = 1;
      if (q.size() == W) begin
        m_trim = '0;
        for (int i = 0; i < W; i++) m_trim = {m_trim[W-2:0], q[i]};
        m_valid = 1;
        m_busy  = 0;
        q.delete();
      end
    end else if (m_busy) begin
      if (since == TO - 1) begin
        m_ferr = 1;
        m_busy = 0;
        since  = 0;
        q.delete();
      end else begin
        since++;
      end
    end
    eh = {eh[1:0], enclk};
    dh = {dh[1:0], din};
  endtask

  task automatic check_outputs();
    chk("trimcode", 32'(trimcode), 32'(m_trim));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_err", 32'(ferr), 32'(m_ferr));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_bit(input bit b, input int lo, input int hi);
    enclk = 1'b0;
    din   = b;
    repeat (lo) tick();
    enclk = 1'b1;
    repeat (hi) tick();
  endtask

  task automatic send_word(input logic [W-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[W-1-i], 20, 20);
  endtask

  task automatic do_reset(input int cycles, input bit lvl);
    rst   = 1'b1;
    enclk = lvl;
    model_reset();
    #1;
    check_outputs();
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    enclk = 1'b1;
    din   = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    repeat (3) tick();
    rst = 1'b0;

    send_word(12'hA5C, W);
    repeat (10) tick();

    send_word(12'hFFF, W);
    send_word(12'h001, W);
    repeat (10) tick();

    send_word(12'h3C3, W);
    send_word(12'h9E7, 5);
    repeat (100) tick();
    send_word(12'h123, W);
    repeat (5) tick();

    send_word(12'hABC, 7);
    do_reset(3, 1'b0);
    send_word(12'h456, W);
    repeat (5) tick();

    do_reset(3, 1'b1);
    repeat (100) tick();
    send_word(12'h789, W);
    repeat (5) tick();

    // Rise lands exactly on the last timeout cycle (gap 64), then one cycle too late (gap 65).
    for (int i = 0; i < W; i++) send_bit(i[0], (i == 6) ? 44 : 20, 20);
    repeat (5) tick();
    for (int i = 0; i < W; i++) send_bit(i[1], (i == 4) ? 45 : 20, 20);
    repeat (80) tick();

    for (int f = 0; f < 30; f++) begin
      logic [W-1:0] w;
      int mode;
      w    = W'($urandom);
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        send_word(w, $urandom_range(1, W - 1));
        repeat ($urandom_range(66, 80)) tick();
      end else if (mode == 1) begin
        send_word(w, $urandom_range(1, W - 1));
        do_reset($urandom_range(1, 4), 1'($urandom));
      end else begin
        for (int i = 0; i < W; i++)
          send_bit(w[W-1-i], $urandom_range(4, 45), $urandom_range(4, 30));
      end
      repeat ($urandom_range(0, 20)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
